// File: rtl/spi_ctrl_cmd_sequencer_if.sv
// Bundle of rx FIFO, tx FIFO and register-bank signals of the ctrl-channel command sequencer.
// master = sequencer side, slave = FIFO / register bank side.
interface spi_ctrl_cmd_sequencer_if #(
    parameter int unsigned REG_ADDR_WD = 16,
    parameter int unsigned REG_DATA_WD = 16
);
    logic                   i_rx_fifo_empty;
    logic [8:0]             iv_rx_fifo_dout;
    logic                   o_rx_fifo_rd;
    logic                   i_tx_fifo_full;
    logic                   o_tx_fifo_wr;
    logic [7:0]             ov_tx_fifo_din;
    logic [REG_ADDR_WD-1:0] ov_reg_addr;
    logic [REG_DATA_WD-1:0] ov_reg_wr_data;
    logic                   o_reg_wr_en;
    logic                   o_reg_rd_en;
    logic [REG_DATA_WD-1:0] iv_reg_rd_data;
    logic                   o_busy;
    logic [7:0]             ov_err_cnt;

    modport master (
        input  i_rx_fifo_empty, iv_rx_fifo_dout, i_tx_fifo_full, iv_reg_rd_data,
        output o_rx_fifo_rd, o_tx_fifo_wr, ov_tx_fifo_din, ov_reg_addr, ov_reg_wr_data,
               o_reg_wr_en, o_reg_rd_en, o_busy, ov_err_cnt
    );

    modport slave (
        output i_rx_fifo_empty, iv_rx_fifo_dout, i_tx_fifo_full, iv_reg_rd_data,
        input  o_rx_fifo_rd, o_tx_fifo_wr, ov_tx_fifo_din, ov_reg_addr, ov_reg_wr_data,
               o_reg_wr_en, o_reg_rd_en, o_busy, ov_err_cnt
    );
endinterface

// File: rtl/spi_ctrl_cmd_sequencer.sv
// Decodes 5-word SPI command frames from the rx FIFO into register write/read strobes and
// returns read data MSB-first through the tx FIFO. Optional macro SPI_CTRL_ADDR_CHECK_EN adds an address range check.
module spi_ctrl_cmd_sequencer #(
    parameter int unsigned             REG_ADDR_WD    = 16,
    parameter int unsigned             REG_DATA_WD    = 16,
    parameter int unsigned             RD_LATENCY     = 2,
    parameter int unsigned             TIMEOUT_CYCLES = 4096,
    parameter logic [REG_ADDR_WD-1:0]  REG_ADDR_MAX   = 16'h01FF
) (
    input  logic                      clk,
    input  logic                      reset,
    spi_ctrl_cmd_sequencer_if.master  bus
);

`ifdef SPI_CTRL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LW = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_EXEC, S_RD_WAIT, S_PUSH_H, S_PUSH_L
    } state_t;

    state_t                 state;
    logic                   rd_q;
    logic [2:0]             idx;
    logic                   is_rd;
    logic                   addr_bad_q;
    logic [7:0]             addr_h;
    logic [7:0]             addr_l;
    logic [7:0]             data_h;
    logic [TW-1:0]          tcnt;
    logic [LW-1:0]          lcnt;
    logic [REG_DATA_WD-1:0] rdata;
    logic [REG_ADDR_WD-1:0] reg_addr;
    logic [REG_DATA_WD-1:0] wr_data;
    logic                   wr_en;
    logic                   rd_en;
    logic [7:0]             err_cnt;

    logic                   collecting;
    logic                   pop;
    logic [8:0]             word;
    logic                   is_cmd;
    logic                   cmd_ok;
    logic [REG_ADDR_WD-1:0] frame_addr;
    logic                   addr_bad;
    logic                   timeout_hit;
    logic                   last_word;
    logic [1:0]             err_add;
    logic [8:0]             err_sum;

    assign collecting  = (state == S_IDLE) || (state == S_COLLECT);
    // Combinational pop keeps the empty check current; rd_q enforces one word in flight.
    assign pop         = collecting && !bus.i_rx_fifo_empty && !rd_q && !reset;
    assign word        = bus.iv_rx_fifo_dout;
    assign is_cmd      = word[8];
    assign cmd_ok      = (word == 9'h180) || (word == 9'h181);
    assign frame_addr  = REG_ADDR_WD'({addr_h, addr_l});
    assign addr_bad    = ADDR_CHECK && (frame_addr > REG_ADDR_MAX);
    assign timeout_hit = (state == S_COLLECT) && !rd_q && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_word   = (state == S_COLLECT) && rd_q && !is_cmd && (idx == 3'd4);

    // A resync word that is itself illegal counts twice: once for the abort, once for the decode.
    always_comb begin
        err_add = '0;
        if (rd_q && collecting && is_cmd) begin
            if (state == S_COLLECT) err_add = err_add + 2'd1;
            if (!cmd_ok)            err_add = err_add + 2'd1;
        end
        if (timeout_hit)            err_add = err_add + 2'd1;
        if (last_word && addr_bad)  err_add = err_add + 2'd1;
    end

    assign err_sum = {1'b0, err_cnt} + 9'(err_add);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_q       <= 1'b0;
            idx        <= '0;
            is_rd      <= 1'b0;
            addr_bad_q <= 1'b0;
            addr_h     <= '0;
            addr_l     <= '0;
            data_h     <= '0;
            tcnt       <= '0;
            lcnt       <= '0;
            rdata      <= '0;
            reg_addr   <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            rd_q    <= pop;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (rd_q) begin
                        tcnt <= '0;
                        if (is_cmd) begin
                            if (cmd_ok) begin
                                state <= S_COLLECT;
                                is_rd <= word[0];
                                idx   <= 3'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (state == S_COLLECT) begin
                            idx <= idx + 3'd1;
                            case (idx)
                                3'd1: addr_h <= word[7:0];
                                3'd2: addr_l <= word[7:0];
                                3'd3: data_h <= word[7:0];
                                default: begin
                                    // Strobes are launched here so they are high during EXEC.
                                    state      <= S_EXEC;
                                    reg_addr   <= frame_addr;
                                    addr_bad_q <= addr_bad;
                                    if (!addr_bad) begin
                                        if (is_rd) begin
                                            rd_en <= 1'b1;
                                        end else begin
                                            wr_en   <= 1'b1;
                                            wr_data <= REG_DATA_WD'({data_h, word[7:0]});
                                        end
                                    end
                                end
                            endcase
                        end
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                        tcnt  <= '0;
                    end else if (state == S_COLLECT) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_EXEC: begin
                    if (!is_rd) begin
                        state <= S_IDLE;
                    end else if (addr_bad_q) begin
                        rdata <= '1;
                        state <= S_PUSH_H;
                    end else begin
                        lcnt  <= LW'(1);
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lcnt == LW'(RD_LATENCY)) begin
                        rdata <= bus.iv_reg_rd_data;
                        state <= S_PUSH_H;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                S_PUSH_H: if (!bus.i_tx_fifo_full) state <= S_PUSH_L;
                S_PUSH_L: if (!bus.i_tx_fifo_full) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Push is gated by the live full flag so no byte is written into a full FIFO.
    assign bus.o_tx_fifo_wr   = ((state == S_PUSH_H) || (state == S_PUSH_L)) && !bus.i_tx_fifo_full;
    assign bus.ov_tx_fifo_din = (state == S_PUSH_H) ? rdata[15:8] :
                                (state == S_PUSH_L) ? rdata[7:0]  : 8'h00;
    assign bus.o_rx_fifo_rd   = pop;
    assign bus.ov_reg_addr    = reg_addr;
    assign bus.ov_reg_wr_data = wr_data;
    assign bus.o_reg_wr_en    = wr_en;
    assign bus.o_reg_rd_en    = rd_en;
    assign bus.o_busy         = (state != S_IDLE);
    assign bus.ov_err_cnt     = err_cnt;

endmodule
